// File: rtl/cp0_vectored_irq_if.sv
// rtl/cp0_vectored_irq_if.sv - CP0 pipeline-side bus bundle
// Purpose: groups the pipeline <-> CP0 signals: register read (ID stage),
//   register write / ERET (EXE stage), interrupt inputs and the PC force-jump path.
// Ports (members):
//   oper      2   00 none, 01 MFC0, 10 MTC0, 11 ERET
//   addr_r    5   read address;  data_r 32 read data (combinational)
//   addr_w    5   write address; data_w 32 write data
//   ir_en     1   pipeline may accept an interrupt this cycle
//   ir_in     NUM_IRQ  level interrupt lines, active-high
//   ret_addr  32  address saved to EPC on entry
//   jump_en   1   force PC jump this cycle; jump_addr 32 jump target
// Modports: master = pipeline side, slave = CP0.
interface cp0_vectored_irq_if #(
  parameter int NUM_IRQ = 4
);
  logic [1:0]         oper;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic [4:0]         addr_w;
  logic [31:0]        data_w;
  logic               ir_en;
  logic [NUM_IRQ-1:0] ir_in;
  logic [31:0]        ret_addr;
  logic               jump_en;
  logic [31:0]        jump_addr;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr
  );
endinterface

// File: rtl/cp0_vectored_irq.sv
// rtl/cp0_vectored_irq.sv - vectored-interrupt CP0 with EPC/CAUSE and ERET
// Purpose: NUM_IRQ sticky-pending interrupt lines, STATUS mask/IE, fixed priority
//   (line 0 highest), vectored entry at EBASE + (id << VEC_SHIFT), single-level
//   handler with ERET return.
// Ports:
//   clk  1  main clock
//   rst  1  synchronous reset, active-high
//   bus     cp0_vectored_irq_if.slave (see interface file for members)
// Register map: 12 STATUS {MASK@[8+:N], IE@0}, 13 CAUSE {PEND@[8+:N], CODE@[4:2]},
//   14 EPC, 15 EBASE. Everything else reads 0 and ignores writes.
module cp0_vectored_irq #(
  parameter int          NUM_IRQ   = 4,
  parameter int          VEC_SHIFT = 3,
  parameter logic [31:0] BASE_RST  = 32'h0000_0008
) (
  input  logic              clk,
  input  logic              rst,
  cp0_vectored_irq_if.slave bus
);

  localparam logic [1:0] OP_MTC0 = 2'b10;
  localparam logic [1:0] OP_ERET = 2'b11;
  localparam logic [NUM_IRQ-1:0] LINE0 = NUM_IRQ'(1);

  typedef enum logic {IDLE, HANDLER} state_e;

  state_e             state_q, state_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [2:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        ebase_q, ebase_d;

  logic [NUM_IRQ-1:0] masked;
  logic [2:0]         id;
  logic               is_eret, is_mtc0, take;

  // Decision logic: priority select and the combinational jump path.
  always_comb begin
    masked  = pend_q & mask_q;
    id      = 3'd0;
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) id = 3'(i);
    end
    is_eret = (bus.oper == OP_ERET);
    is_mtc0 = (bus.oper == OP_MTC0);
    take    = (state_q == IDLE) && bus.ir_en && ie_q && (|masked) && !is_eret;

    bus.jump_en   = 1'b0;
    bus.jump_addr = 32'd0;
    if (!rst) begin
      if (is_eret) begin
        bus.jump_en   = 1'b1;
        bus.jump_addr = epc_q;
      end else if (take) begin
        bus.jump_en   = 1'b1;
        bus.jump_addr = ebase_q + (32'(id) << VEC_SHIFT);
      end
    end
  end

  // Register read port; shows pre-edge contents (no write bypass).
  always_comb begin
    bus.data_r = 32'd0;
    case (bus.addr_r)
      5'd12:   bus.data_r = (32'(mask_q) << 8) | 32'(ie_q);
      5'd13:   bus.data_r = (32'(pend_q) << 8) | (32'(code_q) << 2);
      5'd14:   bus.data_r = epc_q;
      5'd15:   bus.data_r = ebase_q;
      default: bus.data_r = 32'd0;
    endcase
  end

  // Next-state: MTC0 first, entry updates override it, new requests set last
  // so a set always beats a clear in the same cycle.
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    code_d  = code_q;
    epc_d   = epc_q;
    ebase_d = ebase_q;

    if (is_mtc0) begin
      case (bus.addr_w)
        5'd12: begin
          ie_d   = bus.data_w[0];
          mask_d = bus.data_w[8 +: NUM_IRQ];
        end
        5'd13: begin
          code_d = bus.data_w[4:2];
          pend_d = pend_q & ~bus.data_w[8 +: NUM_IRQ];
        end
        5'd14:   epc_d   = bus.data_w;
        5'd15:   ebase_d = bus.data_w;
        default: ;
      endcase
    end

    if (take) begin
      epc_d   = bus.ret_addr;
      code_d  = id;
      pend_d  = pend_d & ~(LINE0 << id);
      state_d = HANDLER;
    end

    if (is_eret) state_d = IDLE;

    pend_d = pend_d | bus.ir_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ie_q    <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      code_q  <= 3'd0;
      epc_q   <= 32'd0;
      ebase_q <= BASE_RST;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      ebase_q <= ebase_d;
    end
  end

endmodule
